// File: rtl/multi_timer_pkg.sv
// Shared definitions for the multi-channel timer: FSM states, register offsets,
// CTRL bit positions and MODE codes.
package multi_timer_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StCnt  = 2'd2,
    StInt  = 2'd3
  } tc_state_e;

  // Byte offsets within one channel's 16-byte window
  localparam logic [3:0] OffCtrl   = 4'h0;
  localparam logic [3:0] OffPreset = 4'h4;
  localparam logic [3:0] OffCount  = 4'h8;
  localparam logic [3:0] OffStatus = 4'hC;

  localparam int unsigned CtrlEnBit     = 0;
  localparam int unsigned CtrlModeBit   = 1;
  localparam int unsigned CtrlImBit     = 3;
  localparam int unsigned StatusPendBit = 0;

  localparam logic ModeOneShot  = 1'b0;
  localparam logic ModePeriodic = 1'b1;

  function automatic logic [31:0] ctrl_word(logic en, logic mode, logic im);
    logic [31:0] w;
    w = '0;
    w[CtrlEnBit]   = en;
    w[CtrlModeBit] = mode;
    w[CtrlImBit]   = im;
    return w;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: CTRL/PRESET/COUNT/STATUS registers and the
// IDLE -> LOAD -> CNT -> INT countdown FSM.
module timer_channel
  import multi_timer_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ctrl_we,
  input  logic             preset_we,
  input  logic             status_we,
  input  logic [31:0]      din,
  output logic             en,
  output logic             mode,
  output logic             im,
  output logic [CNT_W-1:0] preset,
  output logic [CNT_W-1:0] count,
  output logic             pending
);

  tc_state_e        state_q, state_d;
  logic             en_q, en_d;
  logic             mode_q, im_q;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] preset_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             fsm_clr_en;
  logic             pend_set;
  logic             unused_din;

  assign unused_din = ^din;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    fsm_clr_en = 1'b0;
    pend_set   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en_q) state_d = StLoad;
      end
      StLoad: begin
        count_d = preset_q;
        state_d = StCnt;
      end
      StCnt: begin
        if (!en_q) begin
          state_d = StIdle;
        end else if (count_q > CNT_W'(1)) begin
          count_d = count_q - CNT_W'(1);
        end else begin
          // count of 0 or 1 both expire here, so PRESET=0 acts like PRESET=1
          count_d  = '0;
          pend_set = 1'b1;
          state_d  = StInt;
        end
      end
      StInt: begin
        if (mode_q == ModePeriodic) begin
          state_d = StLoad;
        end else begin
          fsm_clr_en = 1'b1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A bus write to CTRL overrides the one-shot auto-clear of EN
  assign en_d   = ctrl_we ? din[CtrlEnBit] : (en_q & ~fsm_clr_en);
  // Expiry set beats a simultaneous write-1-to-clear
  assign pend_d = pend_set | (pend_q & ~(status_we & din[StatusPendBit]));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      en_q     <= 1'b0;
      mode_q   <= ModeOneShot;
      im_q     <= 1'b0;
      pend_q   <= 1'b0;
      preset_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      en_q    <= en_d;
      pend_q  <= pend_d;
      if (ctrl_we) begin
        mode_q <= din[CtrlModeBit];
        im_q   <= din[CtrlImBit];
      end
      if (preset_we) preset_q <= din[CNT_W-1:0];
    end
  end

  assign en      = en_q;
  assign mode    = mode_q;
  assign im      = im_q;
  assign preset  = preset_q;
  assign count   = count_q;
  assign pending = pend_q;

endmodule

// File: rtl/multi_timer.sv
// Multi-channel countdown timer: address decode, read mux and IRQ combine
// around NUM_CH independent timer_channel instances.
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CNT_W  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  logic [2:0]       ch_sel;
  logic [3:0]       reg_off;
  logic             unused_addr;
  logic [NUM_CH-1:0] ch_en, ch_mode, ch_im, ch_pend;
  logic [CNT_W-1:0] ch_preset [NUM_CH];
  logic [CNT_W-1:0] ch_count  [NUM_CH];

  assign ch_sel      = Addr[6:4];
  assign reg_off     = {Addr[3:2], 2'b00};
  assign unused_addr = ^Addr[1:0];

  // Channel indices >= NUM_CH never match, so their writes fall away
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic ch_we;
    assign ch_we = WE && (ch_sel == 3'(g));

    timer_channel #(
      .CNT_W(CNT_W)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .ctrl_we  (ch_we && (reg_off == OffCtrl)),
      .preset_we(ch_we && (reg_off == OffPreset)),
      .status_we(ch_we && (reg_off == OffStatus)),
      .din      (Din),
      .en       (ch_en[g]),
      .mode     (ch_mode[g]),
      .im       (ch_im[g]),
      .preset   (ch_preset[g]),
      .count    (ch_count[g]),
      .pending  (ch_pend[g])
    );
  end

  always_comb begin
    Dout = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == 3'(i)) begin
        case (reg_off)
          OffCtrl:   Dout = ctrl_word(ch_en[i], ch_mode[i], ch_im[i]);
          OffPreset: Dout = 32'(ch_preset[i]);
          OffCount:  Dout = 32'(ch_count[i]);
          OffStatus: Dout = 32'(ch_pend[i]);
          default:   Dout = '0;
        endcase
      end
    end
  end

  assign IRQ = |(ch_pend & ch_im);

endmodule

// File: tb/tb_multi_timer.sv
// Bench for multi_timer: register-access vector table, directed timing
// sequences, and random traffic against a timeline reference model.
module tb_multi_timer;

  localparam int unsigned NumCh = 2;
  localparam int unsigned CntW  = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  int total = 0;
  int bad   = 0;

  multi_timer #(
    .NUM_CH(NumCh),
    .CNT_W (CntW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .Addr (Addr),
    .WE   (WE),
    .Din  (Din),
    .Dout (Dout),
    .IRQ  (IRQ)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive at the falling edge; the write lands on the following rising edge
  task automatic wr(input logic [6:0] a, input logic [31:0] d);
    @(negedge clk);
    Addr = a;
    Din  = d;
    WE   = 1'b1;
    @(posedge clk);
    #1;
    WE = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [6:0] a, input logic [31:0] exp);
    Addr = a;
    #1;
    check(name, Dout, exp);
  endtask

  task automatic irq_chk(input string name, input logic exp);
    check(name, {31'b0, IRQ}, {31'b0, exp});
  endtask

  // ---------------- reference model ----------------
  // A run starts at the edge an idle, enabled channel is seen; t counts edges
  // since then: edge 1 loads, edges 2..span count, edge span+1 expires,
  // edge span+2 ends the run (restart if periodic).
  logic        m_en   [NumCh];
  logic        m_mode [NumCh];
  logic        m_im   [NumCh];
  logic        m_pend [NumCh];
  logic [31:0] m_preset [NumCh];
  logic [31:0] m_count  [NumCh];
  logic [31:0] m_snap   [NumCh];
  bit          m_act  [NumCh];
  int          m_t    [NumCh];

  function automatic void model_reset();
    for (int c = 0; c < NumCh; c++) begin
      m_en[c] = 0; m_mode[c] = 0; m_im[c] = 0; m_pend[c] = 0;
      m_preset[c] = 0; m_count[c] = 0; m_snap[c] = 0; m_act[c] = 0; m_t[c] = 0;
    end
  endfunction

  function automatic void model_step(logic we, logic [6:0] a, logic [31:0] d);
    for (int c = 0; c < NumCh; c++) begin
      bit clr_en;
      bit set;
      bit hit;
      int span;
      int tn;
      clr_en = 0;
      set    = 0;
      hit    = we && (a[6:4] == 3'(c));
      if (!m_act[c]) begin
        if (m_en[c]) begin
          m_act[c] = 1;
          m_t[c]   = 0;
        end
      end else begin
        tn = m_t[c] + 1;
        if (tn == 1) begin
          m_snap[c]  = m_preset[c];
          m_count[c] = m_preset[c];
        end else begin
          span = (m_snap[c] == 0) ? 1 : int'(m_snap[c]);
          if (tn <= span + 1 && !m_en[c]) m_act[c] = 0;
          else if (tn <= span) m_count[c] = m_snap[c] - 32'(tn - 1);
          else if (tn == span + 1) begin
            m_count[c] = 0;
            set = 1;
          end else if (m_mode[c]) tn = 0;
          else begin
            clr_en   = 1;
            m_act[c] = 0;
          end
        end
        m_t[c] = tn;
      end
      if (clr_en) m_en[c] = 0;
      if (hit) begin
        case (a[3:2])
          2'd0: begin m_en[c] = d[0]; m_mode[c] = d[1]; m_im[c] = d[3]; end
          2'd1: m_preset[c] = d;
          2'd3: if (d[0]) m_pend[c] = 0;
          default: ;
        endcase
      end
      if (set) m_pend[c] = 1;
    end
  endfunction

  function automatic logic [31:0] model_read(logic [6:0] a);
    int c;
    c = int'(a[6:4]);
    if (c >= NumCh) return 32'h0;
    case (a[3:2])
      2'd0: return {28'b0, m_im[c], 1'b0, m_mode[c], m_en[c]};
      2'd1: return m_preset[c];
      2'd2: return m_count[c];
      default: return {31'b0, m_pend[c]};
    endcase
  endfunction

  function automatic logic model_irq();
    logic r;
    r = 0;
    for (int c = 0; c < NumCh; c++) r |= m_pend[c] & m_im[c];
    return r;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic        we;
    logic [6:0]  waddr;
    logic [31:0] wdata;
    logic [6:0]  raddr;
    logic [31:0] rexp;
    logic        irq;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(logic we, logic [6:0] wa, logic [31:0] wd,
                                  logic [6:0] ra, logic [31:0] re);
    vec_t v;
    v.we = we; v.waddr = wa; v.wdata = wd; v.raddr = ra; v.rexp = re; v.irq = 1'b0;
    vecs.push_back(v);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [6:0]  ra;
  logic [6:0]  wa;
  logic [31:0] wd;
  logic [2:0]  ch;

  initial begin
    reset = 1'b1;
    WE    = 1'b0;
    Addr  = 7'h00;
    Din   = 32'h0;
    #2;
    rd_chk("rst_ctrl", 7'h00, 32'h0);
    rd_chk("rst_status", 7'h1C, 32'h0);
    irq_chk("rst_irq", 1'b0);
    @(negedge clk);
    reset = 1'b0;

    add_vec(0, 7'h00, 32'h0,        7'h04, 32'h0);
    add_vec(0, 7'h00, 32'h0,        7'h08, 32'h0);
    add_vec(0, 7'h00, 32'h0,        7'h1C, 32'h0);
    add_vec(1, 7'h04, 32'hDEADBEEF, 7'h04, 32'hDEADBEEF);
    add_vec(0, 7'h00, 32'h0,        7'h07, 32'hDEADBEEF);
    add_vec(1, 7'h00, 32'hFFFFFFF6, 7'h00, 32'h2);
    add_vec(1, 7'h08, 32'h00001234, 7'h08, 32'h0);
    add_vec(1, 7'h14, 32'h00000055, 7'h14, 32'h55);
    add_vec(1, 7'h1C, 32'h00000001, 7'h1C, 32'h0);
    add_vec(1, 7'h54, 32'h000000AA, 7'h54, 32'h0);
    add_vec(1, 7'h00, 32'h0,        7'h00, 32'h0);
    add_vec(1, 7'h04, 32'h0,        7'h04, 32'h0);
    add_vec(1, 7'h14, 32'h0,        7'h14, 32'h0);
    foreach (vecs[i]) begin
      if (vecs[i].we) wr(vecs[i].waddr, vecs[i].wdata);
      else tick(1);
      rd_chk($sformatf("vec%0d", i), vecs[i].raddr, vecs[i].rexp);
      irq_chk($sformatf("vec%0d_irq", i), vecs[i].irq);
    end

    // One-shot, IM=1, PRESET=5
    wr(7'h04, 32'd5);
    wr(7'h00, 32'h9);
    tick(2); rd_chk("os_count_e2", 7'h08, 32'd5);
    tick(4); rd_chk("os_pend_e6", 7'h0C, 32'd0);
    tick(1); rd_chk("os_pend_e7", 7'h0C, 32'd1); irq_chk("os_irq_e7", 1'b1);
    tick(1); rd_chk("os_ctrl_e8", 7'h00, 32'h8); irq_chk("os_irq_e8", 1'b1);
    wr(7'h0C, 32'h1);
    rd_chk("os_pend_clr", 7'h0C, 32'd0); irq_chk("os_irq_clr", 1'b0);

    // Periodic ch1, PRESET=3: expiries every 5 cycles
    wr(7'h14, 32'd3);
    wr(7'h10, 32'hB);
    tick(4); rd_chk("per_pend_e4", 7'h1C, 32'd0);
    tick(1); rd_chk("per_pend_e5", 7'h1C, 32'd1); irq_chk("per_irq_e5", 1'b1);
    wr(7'h1C, 32'h1); rd_chk("per_clr_e6", 7'h1C, 32'd0);
    tick(3); rd_chk("per_pend_e9", 7'h1C, 32'd0);
    tick(1); rd_chk("per_pend_e10", 7'h1C, 32'd1);
    wr(7'h1C, 32'h1); rd_chk("per_clr_e11", 7'h1C, 32'd0);
    tick(3); rd_chk("per_pend_e14", 7'h1C, 32'd0);
    wr(7'h1C, 32'h1); rd_chk("set_beats_clr_e15", 7'h1C, 32'd1);
    wr(7'h10, 32'h0);
    wr(7'h1C, 32'h1);
    tick(5); rd_chk("per_stopped", 7'h1C, 32'd0); irq_chk("per_stopped_irq", 1'b0);

    // PRESET rewrite mid-count only affects the next load
    wr(7'h04, 32'd100);
    wr(7'h00, 32'h3);
    tick(52); rd_chk("mid_count50", 7'h08, 32'd50);
    wr(7'h04, 32'd2); rd_chk("mid_count49", 7'h08, 32'd49);
    tick(49); rd_chk("mid_pend_e102", 7'h0C, 32'd1); irq_chk("mid_irq_im0", 1'b0);
    tick(2); rd_chk("reload_count2", 7'h08, 32'd2);
    wr(7'h00, 32'h0);
    tick(3); rd_chk("en_clr_hold", 7'h08, 32'd1);
    wr(7'h0C, 32'h1); rd_chk("mid_pend_clr", 7'h0C, 32'd0);

    // IM=0 expiry, then IM enabled afterwards
    wr(7'h04, 32'd2);
    wr(7'h00, 32'h1);
    tick(6); rd_chk("im0_pend", 7'h0C, 32'd1); irq_chk("im0_irq", 1'b0);
    rd_chk("im0_ctrl", 7'h00, 32'h0);
    wr(7'h00, 32'h8); irq_chk("im1_irq", 1'b1);
    wr(7'h0C, 32'h1); irq_chk("im1_irq_clr", 1'b0);
    wr(7'h00, 32'h0);

    // PRESET=0 behaves as 1; CTRL write wins over one-shot EN clear
    wr(7'h04, 32'd0);
    wr(7'h00, 32'h1);
    tick(2); rd_chk("p0_count_e2", 7'h08, 32'd0); rd_chk("p0_pend_e2", 7'h0C, 32'd0);
    tick(1); rd_chk("p0_pend_e3", 7'h0C, 32'd1);
    wr(7'h00, 32'h1); rd_chk("ctrl_wins_e4", 7'h00, 32'h1);
    wr(7'h0C, 32'h1); rd_chk("p0_clr_e5", 7'h0C, 32'd0);
    tick(1); rd_chk("p0_pend_e6", 7'h0C, 32'd0);
    tick(1); rd_chk("p0_pend_e7", 7'h0C, 32'd1);
    wr(7'h00, 32'h0);
    wr(7'h0C, 32'h1);

    // Reset mid-count
    wr(7'h04, 32'd20);
    wr(7'h00, 32'h9);
    tick(15); rd_chk("pre_rst_count7", 7'h08, 32'd7);
    reset = 1'b1;
    #1;
    rd_chk("rst_mid_count", 7'h08, 32'd0);
    rd_chk("rst_mid_ctrl", 7'h00, 32'd0);
    rd_chk("rst_mid_preset", 7'h04, 32'd0);
    irq_chk("rst_mid_irq", 1'b0);
    @(negedge clk);
    reset = 1'b0;
    tick(30);
    rd_chk("post_rst_pend", 7'h0C, 32'd0); irq_chk("post_rst_irq", 1'b0);
    rd_chk("post_rst_count", 7'h08, 32'd0);

    // Channel 5 does not exist
    wr(7'h54, 32'd3);
    wr(7'h50, 32'h9);
    tick(10);
    rd_chk("ch5_ctrl", 7'h50, 32'd0);
    rd_chk("ch5_preset", 7'h54, 32'd0);
    rd_chk("ch5_status", 7'h5C, 32'd0);
    tick(1);
    rd_chk("ch5_noalias0", 7'h00, 32'd0);
    rd_chk("ch5_noalias1", 7'h14, 32'd0);
    irq_chk("ch5_irq", 1'b0);

    // Random traffic against the reference model
    do_reset();
    model_reset();
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      WE = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 4))
          0, 1:    ch = 3'd0;
          2, 3:    ch = 3'd1;
          default: ch = 3'd5;
        endcase
        wa = {ch, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
        case (wa[3:2])
          2'd0:    wd = ($urandom & 32'hFFFF_FFF0) | 32'($urandom_range(0, 15));
          2'd1:    wd = 32'($urandom_range(0, 9));
          2'd2:    wd = $urandom;
          default: wd = {$urandom_range(0, 1) == 0 ? 31'h0 : 31'h7FFF0000,
                         1'($urandom_range(0, 1))};
        endcase
        Addr = wa;
        Din  = wd;
        WE   = 1'b1;
      end
      @(posedge clk);
      model_step(WE, Addr, Din);
      #1;
      WE = 1'b0;
      case ($urandom_range(0, 4))
        0, 1:    ch = 3'd0;
        2, 3:    ch = 3'd1;
        default: ch = 3'd5;
      endcase
      ra = {ch, 2'($urandom_range(0, 3)), 2'b00};
      rd_chk($sformatf("rand%0d_a%02h", n, ra), ra, model_read(ra));
      irq_chk($sformatf("rand%0d_irq", n), model_irq());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
